seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shifter: the next generation of the team's loadable/shift register.
- Adds width generality, four shift modes, a variable shift amount, and a start/ready/done handshake.
- Sits beside the ALU in the multi-cycle RISC-V datapath and executes SLL/SRL/SRA (plus rotate) at one bit position per clock.
- Trades latency for area versus a barrel shifter.

Parameters:
- W, 32, datapath width; power of two, >= 2.
- SW, $clog2(W), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- shamt  input  SW  shift distance, 0..W-1.
- din  input  W  operand.
- abort  input  1  synchronous cancel of an in-flight operation.
- ready  output  1  unit idle, can accept start.
- busy  output  1  operation in progress (SHIFT state).
- done  output  1  one-cycle pulse: result valid.
- result  output  W  shifter accumulator; final value held until next accepted start.

Behaviour:
- Reset: rst=0 asynchronously forces state=IDLE, acc=0, cnt=0, mode_q=00. Outputs: ready=1, busy=0, done=0, result=0.
- State register: IDLE, SHIFT, DONE (2-bit encoding). result is the accumulator acc directly.
- IDLE: ready=1.
  - start=1 latches acc<=din, cnt<=shamt, mode_q<=mode.
  - Next state is DONE if shamt==0, else SHIFT.
  - start=0 holds all state.
- SHIFT: busy=1, ready=0. Each edge applies one 1-bit step to acc per mode_q and decrements cnt.
  - SLL: {acc[W-2:0],0}.
  - SRL: {0,acc[W-1:1]}.
  - SRA: {acc[W-1],acc[W-1:1]}.
  - ROR: {acc[0],acc[W-1:1]}.
  - When cnt==1 at the edge, the last step is applied, cnt becomes 0 and the state moves to DONE.
- DONE: done=1, ready=0, busy=0, for exactly one cycle. Unconditional return to IDLE.
- Latency: with start accepted at edge E, done is high in the cycle after edge E+shamt. shamt=0 gives done right after E.
- Throughput: next start can be accepted shamt+2 cycles after the previous one.
- start outside IDLE is ignored, not queued. din/mode/shamt are sampled only at acceptance; later changes have no effect.
- abort=1 in SHIFT: next edge goes to IDLE, no done pulse, acc keeps its partially shifted value (undefined for use).
- abort in IDLE or DONE: no effect; a DONE pulse still completes.
- abort and start together in IDLE: start wins.
- rst mid-operation: immediate IDLE, acc=0, no done.
- Arithmetic: no carry-out or overflow flag. Bits shifted out are discarded, except in ROR where they wrap around.

Decomposition:
- Shared package holds:
  - mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step1.
  - Combinational, parameter W, inputs mode and operand, output the 1-bit-shifted operand.
  - Instantiated once in the SHIFT datapath; reusable by the ALU.

Test Plan:
- Reset, then start with SLL, din=0x00000001, shamt=4 -> done in the cycle after edge E+4, result=0x00000010, busy high for 4 cycles.
- SRA, din=0x80000000, shamt=31 -> result=0xFFFFFFFF after 31 shift cycles. Repeat with SRL -> result=0x00000001.
- ROR, din=0x00000001, shamt=1 -> result=0x80000000. Then shamt=0 with din=0xDEADBEEF -> done immediately after the accepting edge, result=0xDEADBEEF.
- Start pulsed with new operands during SHIFT and during DONE -> ignored; original result is unaffected; ready is low throughout.
- abort asserted on the 2nd SHIFT cycle of SLL shamt=8 -> IDLE next edge, no done pulse, ready=1. A following start is accepted normally.
- rst driven low mid-SHIFT, asynchronously between edges -> result=0, ready=1, busy=0, done=0 immediately. Operation resumes normally after rst is released.

Source files
------------

// File: rtl/seq_shift_unit_pkg.sv
// seq_shift_unit_pkg: shift-mode and FSM state encodings shared by the shifter and the ALU.
// Revision 1.0
`default_nettype none

package seq_shift_unit_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seq_shift_unit_shift_step1.sv
// shift_step1: combinational single-bit shift/rotate of an operand by mode.
// Revision 1.0
`default_nettype none

module shift_step1
  import seq_shift_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] operand,
  output logic [W-1:0] shifted
);

  always_comb begin
    shifted = operand;
    case (mode)
      SH_SLL:  shifted = {operand[W-2:0], 1'b0};
      SH_SRL:  shifted = {1'b0, operand[W-1:1]};
      SH_SRA:  shifted = {operand[W-1], operand[W-1:1]};
      SH_ROR:  shifted = {operand[0], operand[W-1:1]};
      default: shifted = operand;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter (SLL/SRL/SRA/ROR), one bit position per clock.
// Revision 1.0
`default_nettype none

module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter  int W  = 32,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] shamt,
  input  logic [W-1:0]  din,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result
);

  logic [1:0]    r_state;
  logic [W-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic [1:0]    r_mode_q;
  logic [W-1:0]  w_step;

  shift_step1 #(.W(W)) u_step (
    .mode    (r_mode_q),
    .operand (r_acc),
    .shifted (w_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mode_q <= SH_SLL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start takes priority over a simultaneous abort here
          if (start) begin
            r_acc    <= din;
            r_cnt    <= shamt;
            r_mode_q <= mode;
            r_state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - SW'(1);
            if (r_cnt == SW'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready  = (r_state == ST_IDLE);
  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);
  assign result = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed vector table plus hand sequences for abort, ignore and reset cases.
// Revision 1.0
`default_nettype none

module tb_seq_shift_unit;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic        abort;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passed;
  int total;

  seq_shift_unit #(.W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .shamt  (shamt),
    .din    (din),
    .abort  (abort),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [4:0]  sa;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Issue one operation and check latency, busy length, result and the return to idle.
  task automatic run_op(input logic [1:0] m, input logic [4:0] sa, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    int n;
    int b;
    @(negedge clk);
    mode  = m;
    shamt = sa;
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~m;
    shamt = ~sa;
    din   = ~d;
    n = 0;
    b = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      if (busy) b++;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(sa));
    check({tag, " busy_cycles"}, 32'(b), 32'(sa));
    check({tag, " result"}, result, exp);
    check({tag, " ready_in_done"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, " ready_after"}, 32'(ready), 32'd1);
    check({tag, " result_held"}, result, exp);
  endtask

  initial begin
    int seen_done;
    int ready_hi;
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 2'b00;
    shamt  = '0;
    din    = '0;

    vecs[0]  = '{M_SLL, 5'd4,  32'h0000_0001, 32'h0000_0010};
    vecs[1]  = '{M_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[2]  = '{M_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[3]  = '{M_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000};
    vecs[4]  = '{M_ROR, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5]  = '{M_SLL, 5'd8,  32'hDEAD_BEEF, 32'hADBE_EF00};
    vecs[6]  = '{M_SRA, 5'd3,  32'h7000_0000, 32'h0E00_0000};
    vecs[7]  = '{M_ROR, 5'd4,  32'h1234_5678, 32'h8123_4567};
    vecs[8]  = '{M_SRA, 5'd1,  32'h8000_0001, 32'hC000_0000};
    vecs[9]  = '{M_SLL, 5'd31, 32'h0000_0003, 32'h8000_0000};
    vecs[10] = '{M_SRL, 5'd5,  32'hF000_00FF, 32'h0780_0007};
    vecs[11] = '{M_ROR, 5'd31, 32'h8000_0001, 32'h0000_0003};

    #12;
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].m, vecs[i].sa, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start held high with new operands through SHIFT and DONE must be ignored
    @(negedge clk);
    mode = M_SLL; shamt = 5'd4; din = 32'h1; start = 1'b1;
    @(posedge clk);
    #1;
    mode = M_SRL; shamt = 5'd2; din = 32'hFFFF_FFFF;
    ready_hi = 0;
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready) ready_hi++;
      if (done) seen_done++;
    end
    check("ignore ready_low", 32'(ready_hi), 32'd0);
    check("ignore done_seen", 32'(seen_done), 32'd1);
    check("ignore result", result, 32'h10);
    @(negedge clk);
    check("ignore ready_back", 32'(ready), 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("ignore result_held", result, 32'h10);

    // abort on the second SHIFT cycle
    mode = M_SLL; shamt = 5'd8; din = 32'h1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ready", 32'(ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort no_done", 32'(seen_done), 32'd0);
    run_op(M_SLL, 5'd2, 32'h3, 32'hC, "after_abort");

    // start wins over simultaneous abort in IDLE
    @(negedge clk);
    mode = M_SRL; shamt = 5'd2; din = 32'h8; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_vs_abort busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("start_vs_abort done", 32'(done), 32'd1);
    check("start_vs_abort result", result, 32'h2);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    mode = M_SRA; shamt = 5'd31; din = 32'h8000_0000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst result", result, 32'd0);
    check("async_rst ready", 32'(ready), 32'd1);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(M_ROR, 5'd8, 32'h0000_00AB, 32'hAB00_0000, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
